mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- CPU-side initiator for the data memory's mwr/moe/ma/mwd/mrd port.
- Accepts load/store requests from the execute stage over a valid/ready handshake and sequences memory cycles.
- Implements byte/halfword stores by read-modify-write, and byte/halfword loads by lane extraction with sign or zero extension.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MAX_MEM_INDEX, 127, highest valid word index; must match the data memory depth.
- DATA_W, 32, data and address width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bits used for sub-word stores.
- resp_valid  out  1  response held until consumed.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or reserved-size access.
- mwr  out  1  memory write enable.
- moe  out  1  memory output enable.
- ma  out  32  memory byte address (word-aligned: req_addr with [1:0] cleared).
- mwd  out  32  memory write data.
- mrd  in  32  memory read data; combinational from ma/moe.

Behaviour:
- States: IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP.
- Reset (reset_n low at an edge):
  - State goes to IDLE; all registers clear.
  - resp_valid, resp_err and resp_rdata are 0; req_ready is 1 after the edge.
  - mwr and moe are ANDed with reset_n, so no write occurs in a cycle where reset_n is low, even mid-RMW.
- IDLE:
  - req_ready = 1; the request is latched when req_valid is high at the edge.
  - Error if any of: size 11; half with addr[0] = 1; word with addr[1:0] != 0; (addr >> 2) > MAX_MEM_INDEX. Error goes to RESP with resp_err = 1 and no memory cycle.
  - Otherwise: load goes to LOAD; word store goes to STORE; byte/half store goes to RMW_READ.
- LOAD: moe = 1, ma = aligned address. At the edge, extract the lane selected by addr[1:0] (half uses addr[1]), extend per req_signed, latch into resp_rdata, go to RESP.
- STORE: mwr = 1, mwd = req_wdata. Memory writes at this edge; go to RESP.
- RMW_READ: moe = 1. Latch mrd as the old word; go to RMW_WRITE.
- RMW_WRITE:
  - mwr = 1; mwd = old word with the selected byte/half replaced by req_wdata[7:0] or [15:0].
  - Go to RESP.
- RESP:
  - resp_valid = 1; req_ready = 0.
  - When resp_ready is high, go to IDLE (no same-cycle new accept).
  - Outputs are stable while stalled.
- Outside active states: mwr = moe = 0 and ma = mwd = 0.
- Latency from the accept edge to resp_valid: error 1 cycle; load or word store 2 cycles; sub-word store 3 cycles.
- Throughput: at most one outstanding request.

Optional Feature:
- Macro MEM_ACCESS_STATS_EN.
- Defined: adds outputs load_count, store_count and err_count, each 16 bits.
  - Each increments on entry to RESP for its class and saturates at 0xFFFF.
  - Each clears on reset.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - the state enum;
  - the default MAX_MEM_INDEX;
  - the error-check function.
- Sub-module mem_lane_align (combinational), with two functions:
  - extract and extend a lane from a word;
  - merge a lane into a word.
- The FSM lives in mem_access_unit.

Test Plan:
- Word store, then load: store 0xDEADBEEF to addr 0x10, then load word from 0x10. Expect resp_rdata = 0xDEADBEEF, err = 0, and resp_valid 2 cycles after each accept.
- Byte stores: with word 0x10 = 0xDEADBEEF, store byte 0x55 to 0x11. Expect memory word = 0xDEAD55EF. Then load byte 0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE.
- Half access: store half 0x8001 to 0x22, then signed half load from 0x22. Expect 0xFFFF8001; word 8 upper half = 0x8001 and lower half unchanged.
- Error paths, each giving resp_err = 1, rdata = 0, mwr never asserted, response after 1 cycle:
  - word load at 0x02;
  - half store at 0x05;
  - word store at 0x200 (index 128);
  - size 11.
- Backpressure: hold resp_ready = 0 for 5 cycles. Expect resp_valid and data stable, req_ready = 0, and a second req_valid ignored until consumption.
- Reset mid-RMW: assert reset_n = 0 during RMW_WRITE. Expect no memory write, the target word unchanged, and all outputs 0 with IDLE next cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared size encodings, FSM states and request legality check for the data-memory initiator.
// Misalignment and out-of-range checks are pure combinational helpers.
package mem_access_pkg;

  localparam int unsigned MAX_MEM_INDEX_DEF = 127;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_RMW_READ,
    ST_RMW_WRITE,
    ST_RESP
  } state_e;

  // Any violation skips the memory cycle entirely and answers with resp_err.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr,
                                      input int unsigned max_index);
    logic bad_size, bad_half, bad_word, bad_range;
    bad_size  = (size == SIZE_RSVD);
    bad_half  = (size == SIZE_HALF) && addr[0];
    bad_word  = (size == SIZE_WORD) && (addr[1:0] != 2'b00);
    bad_range = ((addr >> 2) > max_index);
    return bad_size | bad_half | bad_word | bad_range;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the data-memory mwr/moe/ma/mwd/mrd port.
// slave = the access unit; master = execute stage together with the memory.
interface mem_access_unit_if #(parameter int DATA_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mwr;
  logic              moe;
  logic [DATA_W-1:0] ma;
  logic [DATA_W-1:0] mwd;
  logic [DATA_W-1:0] mrd;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready, mrd,
    output req_ready, resp_valid, resp_rdata, resp_err, mwr, moe, ma, mwd
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready, mrd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mwr, moe, ma, mwd
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane handling: extract/extend a byte or half for loads, merge one into a word for stores.
// Zero latency; no flow control of its own.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              sext,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  function automatic logic [DATA_W-1:0] extract_lane(input logic [DATA_W-1:0] w,
                                                     input logic [1:0] sz,
                                                     input logic [1:0] off,
                                                     input logic sx);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      SIZE_BYTE: r = {{(DATA_W-8){sx & b[7]}}, b};
      SIZE_HALF: r = {{(DATA_W-16){sx & h[15]}}, h};
      default:   r = w;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] w,
                                                   input logic [DATA_W-1:0] d,
                                                   input logic [1:0] sz,
                                                   input logic [1:0] off);
    logic [DATA_W-1:0] r;
    r = w;
    case (sz)
      SIZE_BYTE: r[{off, 3'b000} +: 8]     = d[7:0];
      SIZE_HALF: r[{off[1], 4'b0000} +: 16] = d[15:0];
      default:   r = d;
    endcase
    return r;
  endfunction

  assign load_data  = extract_lane(word, size, offset, sext);
  assign merge_data = merge_lane(word, wdata, size, offset);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the data memory: error 1, load/word store 2, sub-word store (RMW) 3 cycles to resp_valid.
// One request outstanding; resp held stable until resp_ready. MEM_ACCESS_STATS_EN adds saturating 16-bit counters.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MAX_MEM_INDEX = MAX_MEM_INDEX_DEF,
  parameter int          DATA_W        = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  mem_access_unit_if.slave   bus
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]        load_count,
  output logic [15:0]        store_count,
  output logic [15:0]        err_count
`endif
);

  state_e            state;
  logic [1:0]        size_q;
  logic [1:0]        offset_q;
  logic              sext_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              mwr_q;
  logic              moe_q;
  logic [DATA_W-1:0] ma_q;
  logic [DATA_W-1:0] mwd_q;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;
  logic              accept_err;
  logic [DATA_W-1:0] aligned_addr;

  assign accept_err   = access_err(bus.req_size, bus.req_addr, MAX_MEM_INDEX);
  assign aligned_addr = {bus.req_addr[DATA_W-1:2], 2'b00};

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .word       (bus.mrd),
    .wdata      (wdata_q),
    .size       (size_q),
    .offset     (offset_q),
    .sext       (sext_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      size_q       <= '0;
      offset_q     <= '0;
      sext_q       <= 1'b0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mwr_q        <= 1'b0;
      moe_q        <= 1'b0;
      ma_q         <= '0;
      mwd_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            size_q   <= bus.req_size;
            offset_q <= bus.req_addr[1:0];
            sext_q   <= bus.req_signed;
            wdata_q  <= bus.req_wdata;
            ready_q  <= 1'b0;
            if (accept_err) begin
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (!bus.req_we) begin
              state <= ST_LOAD;
              moe_q <= 1'b1;
              ma_q  <= aligned_addr;
            end else if (bus.req_size == SIZE_WORD) begin
              state <= ST_STORE;
              mwr_q <= 1'b1;
              ma_q  <= aligned_addr;
              mwd_q <= bus.req_wdata;
            end else begin
              state <= ST_RMW_READ;
              moe_q <= 1'b1;
              ma_q  <= aligned_addr;
            end
          end
        end
        ST_LOAD: begin
          state        <= ST_RESP;
          moe_q        <= 1'b0;
          ma_q         <= '0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_data;
        end
        ST_STORE: begin
          state        <= ST_RESP;
          mwr_q        <= 1'b0;
          ma_q         <= '0;
          mwd_q        <= '0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
        end
        // Old word is on mrd now; the merged word is registered so mwd is stable through the write cycle.
        ST_RMW_READ: begin
          state <= ST_RMW_WRITE;
          moe_q <= 1'b0;
          mwr_q <= 1'b1;
          mwd_q <= merge_data;
        end
        ST_RMW_WRITE: begin
          state        <= ST_RESP;
          mwr_q        <= 1'b0;
          ma_q         <= '0;
          mwd_q        <= '0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state        <= ST_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Gating with reset_n kills a write already launched when reset lands mid-RMW.
  assign bus.mwr        = mwr_q & reset_n;
  assign bus.moe        = moe_q & reset_n;
  assign bus.ma         = ma_q;
  assign bus.mwd        = mwd_q;
  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

`ifdef MEM_ACCESS_STATS_EN
  logic enter_load, enter_store, enter_err;

  assign enter_err   = (state == ST_IDLE) && bus.req_valid && accept_err;
  assign enter_load  = (state == ST_LOAD);
  assign enter_store = (state == ST_STORE) || (state == ST_RMW_WRITE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      load_count  <= '0;
      store_count <= '0;
      err_count   <= '0;
    end else begin
      if (enter_load && (load_count != 16'hFFFF))   load_count  <= load_count + 16'd1;
      if (enter_store && (store_count != 16'hFFFF)) store_count <= store_count + 16'd1;
      if (enter_err && (err_count != 16'hFFFF))     err_count   <= err_count + 16'd1;
    end
  end
`endif

endmodule
